// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load-return alignment stage behind ROM/RAM block memory
//
// Tracks each load through the BRAM read latency, selects the ROM or RAM read
// port, extracts the addressed byte/half/word, extends it and registers the
// result with its destination register for writeback.
//
// Ports:
//   clk           rising-edge system clock
//   rst_n         asynchronous active-low reset
//   flush         kill every in-flight load
//   memOp         00 idle, 01 load ROM, 10 load RAM, 11 store
//   memSize       00 byte, 01 half, 10 word, 11 reserved
//   loadUnsigned  1 = zero-extend, 0 = sign-extend
//   addr          request byte address (only [1:0] matters)
//   rd            destination register of the load
//   romDout       ROM port-B read data
//   ramDout       RAM port-B read data
//   loadValid     one-cycle pulse: loadData/loadRd valid
//   loadData      aligned, extended load result
//   loadRd        destination register for loadData
//   loadErr       one-cycle pulse: misaligned/reserved-size load retired
//   busy          a load is in flight or showing on the outputs

module mem_load_align #(
  parameter int READ_LATENCY = 1,
  parameter int RD_W         = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [1:0]      memOp,
  input  logic [1:0]      memSize,
  input  logic            loadUnsigned,
  input  logic [31:0]     addr,
  input  logic [RD_W-1:0] rd,
  input  logic [31:0]     romDout,
  input  logic [31:0]     ramDout,
  output logic            loadValid,
  output logic [31:0]     loadData,
  output logic [RD_W-1:0] loadRd,
  output logic            loadErr,
  output logic            busy
);

  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("mem_load_align: READ_LATENCY must be in 1..3");
  end

  typedef struct packed {
    logic            v;
    logic            src;   // 0 = ROM, 1 = RAM
    logic [1:0]      size;
    logic            uns;
    logic [1:0]      off;
    logic [RD_W-1:0] rd;
    logic            err;
  } tag_t;

  tag_t tag_q [READ_LATENCY];
  tag_t tag_in;
  tag_t last;

  logic [31:0] word_sel;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] result;

  // Upper address bits are irrelevant to alignment.
  logic unused_addr;
  assign unused_addr = &{1'b0, addr[31:2]};

  // New tag from the request; stores and idle cycles never become valid.
  always_comb begin
    tag_in      = '0;
    tag_in.v    = (memOp == 2'b01 || memOp == 2'b10) && !flush;
    tag_in.src  = (memOp == 2'b10);
    tag_in.size = memSize;
    tag_in.uns  = loadUnsigned;
    tag_in.off  = addr[1:0];
    tag_in.rd   = rd;
    tag_in.err  = (memSize == 2'b11)
                || (memSize == 2'b01 && addr[0])
                || (memSize == 2'b10 && addr[1:0] != 2'b00);
  end

  // Tag shift register: no stall, one entry per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (flush) begin
        for (int i = 0; i < READ_LATENCY; i++) begin
          tag_q[i].v <= 1'b0;
        end
      end
    end
  end

  assign last     = tag_q[READ_LATENCY-1];
  assign word_sel = last.src ? ramDout : romDout;

  always_comb begin
    byte_sel = word_sel[7:0];
    case (last.off)
      2'd0: byte_sel = word_sel[7:0];
      2'd1: byte_sel = word_sel[15:8];
      2'd2: byte_sel = word_sel[23:16];
      2'd3: byte_sel = word_sel[31:24];
      default: byte_sel = word_sel[7:0];
    endcase
  end

  // Only off 0/2 reach here without err, so off[1] picks the half.
  assign half_sel = last.off[1] ? word_sel[31:16] : word_sel[15:0];

  always_comb begin
    result = word_sel;
    case (last.size)
      2'b00: result = last.uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01: result = last.uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: result = word_sel;
    endcase
  end

  // Output register; data/rd hold between retires, error retire zeroes data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadValid <= 1'b0;
      loadErr   <= 1'b0;
      loadData  <= '0;
      loadRd    <= '0;
    end else if (flush) begin
      loadValid <= 1'b0;
      loadErr   <= 1'b0;
    end else begin
      loadValid <= last.v && !last.err;
      loadErr   <= last.v && last.err;
      if (last.v) begin
        loadRd   <= last.rd;
        loadData <= last.err ? 32'h0 : result;
      end
    end
  end

  always_comb begin
    busy = loadValid | loadErr;
    for (int i = 0; i < READ_LATENCY; i++) begin
      busy = busy | tag_q[i].v;
    end
  end

endmodule

// File: tb/tb_mem_load_align.sv
// tb/tb_mem_load_align.sv - directed self-checking bench for mem_load_align

module tb_mem_load_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush1, flush3;
  logic [1:0]  memOp, memSize;
  logic        loadUnsigned;
  logic [31:0] addr;
  logic [4:0]  rd;
  logic [31:0] romDout, ramDout;

  logic        loadValid1, loadErr1, busy1;
  logic [31:0] loadData1;
  logic [4:0]  loadRd1;
  logic        loadValid3, loadErr3, busy3;
  logic [31:0] loadData3;
  logic [4:0]  loadRd3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_load_align #(.READ_LATENCY(1), .RD_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .memOp(memOp), .memSize(memSize),
    .loadUnsigned(loadUnsigned), .addr(addr), .rd(rd), .romDout(romDout), .ramDout(ramDout),
    .loadValid(loadValid1), .loadData(loadData1), .loadRd(loadRd1), .loadErr(loadErr1), .busy(busy1)
  );

  mem_load_align #(.READ_LATENCY(3), .RD_W(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .memOp(memOp), .memSize(memSize),
    .loadUnsigned(loadUnsigned), .addr(addr), .rd(rd), .romDout(romDout), .ramDout(ramDout),
    .loadValid(loadValid3), .loadData(loadData3), .loadRd(loadRd3), .loadErr(loadErr3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [4:0] r);
    memOp = op; memSize = sz; loadUnsigned = uns; addr = a; rd = r;
  endtask

  task automatic idle();
    memOp = 2'b00;
  endtask

  // One load on the latency-1 instance; returns at the negedge of cycle N+2.
  task automatic run1(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [4:0] r,
                      input logic [31:0] rom, input logic [31:0] ram);
    tick(); req(op, sz, uns, a, r);
    tick(); idle(); romDout = rom; ramDout = ram;
    tick();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush1 = 1'b0; flush3 = 1'b0;
    memOp = 2'b00; memSize = 2'b00; loadUnsigned = 1'b0; addr = '0; rd = '0;
    romDout = '0; ramDout = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", loadValid1, 0);
    chk("reset_err",   loadErr1, 0);
    chk("reset_data",  loadData1, 0);
    chk("reset_rd",    loadRd1, 0);
    chk("reset_busy",  busy1, 0);
    chk("reset_busy3", busy3, 0);

    // lb RAM addr 0x1003 with latency check
    tick(); req(2'b10, 2'b00, 1'b0, 32'h1003, 5'd5);
    tick(); idle(); ramDout = 32'h80FF1234;
    @(negedge clk);
    chk("lb_n1_valid", loadValid1, 0);
    chk("lb_n1_busy",  busy1, 1);
    tick(); @(negedge clk);
    chk("lb_valid", loadValid1, 1);
    chk("lb_data",  loadData1, 32'hFFFFFF80);
    chk("lb_rd",    loadRd1, 5);
    tick(); @(negedge clk);
    chk("lb_pulse_end", loadValid1, 0);
    chk("lb_data_hold", loadData1, 32'hFFFFFF80);
    chk("lb_busy_end",  busy1, 0);

    run1(2'b10, 2'b00, 1'b1, 32'h1003, 5'd6, 32'h0, 32'h80FF1234);
    chk("lbu_data", loadData1, 32'h00000080);
    chk("lbu_rd",   loadRd1, 6);
    run1(2'b10, 2'b00, 1'b1, 32'h0001, 5'd7, 32'h0, 32'h80FF1234);
    chk("lbu_off1_data", loadData1, 32'h00000012);
    run1(2'b01, 2'b01, 1'b1, 32'h0002, 5'd8, 32'h80017FFF, 32'h0);
    chk("lhu_data", loadData1, 32'h00008001);
    run1(2'b01, 2'b01, 1'b0, 32'h0002, 5'd9, 32'h80017FFF, 32'h0);
    chk("lh_data",  loadData1, 32'hFFFF8001);
    chk("lh_valid", loadValid1, 1);
    run1(2'b01, 2'b01, 1'b0, 32'h0000, 5'd10, 32'h80017FFF, 32'h0);
    chk("lh_off0_data", loadData1, 32'h00007FFF);
    run1(2'b10, 2'b10, 1'b1, 32'h0000, 5'd11, 32'h0, 32'hDEADBEEF);
    chk("lw_data", loadData1, 32'hDEADBEEF);

    // Four back-to-back loads; odd rd from ROM, even rd from RAM
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c < 4) req((c % 2 == 0) ? 2'b01 : 2'b10, 2'b10, 1'b0, 32'h0, 5'(c + 1));
      else idle();
      romDout = 32'hA0000000 + c;
      ramDout = 32'hB0000000 + c;
      @(negedge clk);
      chk($sformatf("b2b_valid_c%0d", c), loadValid1, (c >= 2 && c <= 5) ? 1 : 0);
      chk($sformatf("b2b_busy_c%0d", c), busy1, (c >= 1 && c <= 5) ? 1 : 0);
      if (c >= 2 && c <= 5) begin
        chk($sformatf("b2b_rd_c%0d", c), loadRd1, c - 1);
        chk($sformatf("b2b_data_c%0d", c), loadData1,
            ((c - 1) % 2 == 1) ? 32'hA0000000 + (c - 1) : 32'hB0000000 + (c - 1));
      end
    end

    // Error retires and an untracked store
    run1(2'b01, 2'b10, 1'b0, 32'h0002, 5'd7, 32'h12345678, 32'h0);
    chk("lw_mis_err",   loadErr1, 1);
    chk("lw_mis_valid", loadValid1, 0);
    chk("lw_mis_data",  loadData1, 0);
    chk("lw_mis_rd",    loadRd1, 7);
    run1(2'b10, 2'b01, 1'b0, 32'h0001, 5'd12, 32'h0, 32'h12345678);
    chk("lh_mis_err",   loadErr1, 1);
    run1(2'b10, 2'b11, 1'b0, 32'h0000, 5'd9, 32'h0, 32'h12345678);
    chk("rsv_err",   loadErr1, 1);
    chk("rsv_valid", loadValid1, 0);
    chk("rsv_data",  loadData1, 0);
    chk("rsv_rd",    loadRd1, 9);
    tick(); @(negedge clk);
    chk("err_pulse_end", loadErr1, 0);
    tick(); req(2'b11, 2'b10, 1'b0, 32'h0, 5'd13);
    tick(); idle();
    @(negedge clk);
    chk("store_busy", busy1, 0);
    tick(); @(negedge clk);
    chk("store_valid", loadValid1, 0);
    chk("store_err",   loadErr1, 0);
    chk("store_rd",    loadRd1, 9);

    // Latency-3 instance: normal load
    tick(); req(2'b10, 2'b10, 1'b0, 32'h0, 5'd6); ramDout = 32'h12345678;
    tick(); idle();
    tick();
    tick(); @(negedge clk);
    chk("l3_n3_valid", loadValid3, 0);
    chk("l3_n3_busy",  busy3, 1);
    tick(); @(negedge clk);
    chk("l3_valid", loadValid3, 1);
    chk("l3_data",  loadData3, 32'h12345678);
    chk("l3_rd",    loadRd3, 6);
    tick(); @(negedge clk);
    chk("l3_pulse_end", loadValid3, 0);

    // Latency-3 flush with two loads in flight plus a same-cycle request
    tick(); req(2'b10, 2'b10, 1'b0, 32'h0, 5'd1);
    tick(); req(2'b01, 2'b00, 1'b0, 32'h0, 5'd2);
    tick(); req(2'b10, 2'b10, 1'b0, 32'h0, 5'd3); flush3 = 1'b1;
    @(negedge clk);
    chk("fl_busy_before", busy3, 1);
    tick(); idle(); flush3 = 1'b0;
    @(negedge clk);
    chk("fl_busy_after", busy3, 0);
    for (int c = 0; c < 5; c++) begin
      tick(); @(negedge clk);
      chk($sformatf("fl_valid_c%0d", c), loadValid3, 0);
      chk($sformatf("fl_err_c%0d", c), loadErr3, 0);
    end

    // Asynchronous reset mid-flight
    tick(); req(2'b01, 2'b10, 1'b0, 32'h0, 5'd3); romDout = 32'hCAFEF00D;
    tick(); req(2'b10, 2'b10, 1'b0, 32'h0, 5'd4); ramDout = 32'h11112222;
    tick(); idle();
    @(negedge clk);
    chk("rst_pre_valid", loadValid1, 1);
    chk("rst_pre_data",  loadData1, 32'hCAFEF00D);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", loadValid1, 0);
    chk("rst_async_data",  loadData1, 0);
    chk("rst_async_rd",    loadRd1, 0);
    chk("rst_async_busy",  busy1, 0);
    chk("rst_async_busy3", busy3, 0);
    tick(); #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); @(negedge clk);
      chk($sformatf("post_rst_valid_c%0d", c), loadValid1, 0);
      chk($sformatf("post_rst_err_c%0d", c), loadErr1, 0);
      chk($sformatf("post_rst_valid3_c%0d", c), loadValid3, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
